// File: rtl/psr_status_sequencer.sv
// Next-state generator for a 5-bit processor status register: dispatches issues to two timed
// execution paths and retires completed results oldest-first. Optional STATUS_CHECK_EN adds PSR feedback checking.
module psr_status_sequencer #(
    parameter int status_width = 5,
    parameter int LAT_W        = 4
) (
    input  logic                    clk,
    input  logic                    preset_n,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [LAT_W-1:0]        issue_lat,
    input  logic                    result_ack,
    output logic                    result_path,
    input  logic [status_width-1:0] status,
    output logic [status_width-1:0] newstatus,
    output logic                    status_err
);

    typedef enum logic [1:0] {
        PATH_IDLE = 2'd0,
        PATH_BUSY = 2'd1,
        PATH_DONE = 2'd2
    } path_state_t;

    logic [1:0]       idle_vec;
    logic [1:0]       done_vec;
    logic             accept;
    logic             dispatch_path;
    logic             data_ready;
    logic             oldest_done;
    logic             retire;
    logic [LAT_W-1:0] lat_eff;

    logic             age_reg;
    logic             age_next;
    logic [1:0]       last_reg;
    logic [1:0]       last_next;

    assign issue_ready   = idle_vec[0] | idle_vec[1];
    assign accept        = issue_valid & issue_ready;
    // path0 wins whenever it is free; otherwise path1 must be the free one
    assign dispatch_path = ~idle_vec[0];
    assign data_ready    = done_vec[0] | done_vec[1];
    assign oldest_done   = (done_vec[0] & done_vec[1]) ? age_reg : done_vec[1];
    assign retire        = result_ack & data_ready;
    assign lat_eff       = (issue_lat == '0) ? LAT_W'(1) : issue_lat;
    assign result_path   = oldest_done;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_path
            path_state_t      state_reg;
            path_state_t      state_next;
            logic [LAT_W-1:0] cnt_reg;
            logic [LAT_W-1:0] cnt_next;

            always_ff @(posedge clk or negedge preset_n) begin
                if (!preset_n) begin
                    state_reg <= PATH_IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    PATH_IDLE: begin
                        if (accept && (dispatch_path == 1'(gi))) begin
                            state_next = PATH_BUSY;
                            cnt_next   = lat_eff;
                        end
                    end
                    PATH_BUSY: begin
                        cnt_next = cnt_reg - LAT_W'(1);
                        if (cnt_reg <= LAT_W'(1)) begin
                            state_next = PATH_DONE;
                            cnt_next   = '0;
                        end
                    end
                    PATH_DONE: begin
                        if (retire && (oldest_done == 1'(gi))) begin
                            state_next = PATH_IDLE;
                        end
                    end
                    default: begin
                        state_next = PATH_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            assign idle_vec[gi] = (state_reg == PATH_IDLE);
            assign done_vec[gi] = (state_reg == PATH_DONE);
        end
    endgenerate

    always_comb begin
        age_next  = age_reg;
        last_next = last_reg;
        if (accept) begin
            last_next = dispatch_path ? 2'b10 : 2'b01;
            // the path already in flight becomes the older one
            if (dispatch_path || !idle_vec[1]) begin
                age_next = ~dispatch_path;
            end
        end
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            age_reg  <= 1'b0;
            last_reg <= 2'b00;
        end else begin
            age_reg  <= age_next;
            last_reg <= last_next;
        end
    end

    assign newstatus = {data_ready, ~idle_vec[1], ~idle_vec[0], last_reg};

`ifdef STATUS_CHECK_EN
    logic [status_width-1:0] shadow_reg;
    logic                    armed_reg;
    logic                    err_reg;

    // armed_reg skips the first cycle after reset, before the PSR has loaded anything
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            shadow_reg <= '0;
            armed_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            shadow_reg <= newstatus;
            armed_reg  <= 1'b1;
            if (armed_reg && (status != shadow_reg)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign status_err = err_reg;
`else
    logic unused_status;
    assign unused_status = ^status;
    assign status_err    = 1'b0;
`endif

endmodule
